// File: rtl/gate_truth_checker_if.sv
// Stimulus/response bundle between a truth-table checker and its controller.
interface gate_truth_checker_if;
  logic       start;
  logic [3:0] exp_tt;
  logic       y;
  logic       a;
  logic       b;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] measured_tt;
  logic [3:0] fail_mask;
  logic [3:0] xz_mask;

  // Controller side: requests sweeps, owns the gate-under-test output.
  modport master (
    output start, exp_tt, y,
    input  a, b, busy, done, pass, measured_tt, fail_mask, xz_mask
  );

  // Checker side: drives gate inputs and reports the captured table.
  modport slave (
    input  start, exp_tt, y,
    output a, b, busy, done, pass, measured_tt, fail_mask, xz_mask
  );
endinterface

// File: rtl/gate_truth_checker.sv
// Sweeps {a,b} through 00..11, samples y after a settle window and grades
// the captured truth table against the table latched at start.
module gate_truth_checker #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input logic                 clk,
  input logic                 rst,
  gate_truth_checker_if.slave bus
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned IDX_W = 2;
  localparam int unsigned TT_W  = 4;

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TT_W-1:0]   exp_q, exp_d;
  logic              a_d, b_d, busy_d, done_d, pass_d;
  logic [TT_W-1:0]   meas_d, fail_d, xz_d;
  logic              y_one, y_zero, y_xz, row_fail;

  // Classify y with case equality so x/z never masquerade as a clean level.
  always_comb begin
    y_one  = (bus.y === 1'b1);
    y_zero = (bus.y === 1'b0);
    y_xz   = !(y_one || y_zero);
    row_fail = y_xz || (y_one != exp_q[idx_q]);
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    exp_d   = exp_q;
    a_d     = bus.a;
    b_d     = bus.b;
    busy_d  = bus.busy;
    done_d  = 1'b0;
    pass_d  = bus.pass;
    meas_d  = bus.measured_tt;
    fail_d  = bus.fail_mask;
    xz_d    = bus.xz_mask;

    case (state_q)
      IDLE: begin
        a_d    = 1'b0;
        b_d    = 1'b0;
        busy_d = 1'b0;
        if (bus.start) begin
          exp_d   = bus.exp_tt;
          meas_d  = '0;
          fail_d  = '0;
          xz_d    = '0;
          pass_d  = 1'b0;
          idx_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
          state_d = SAMPLE;
        end
      end
      SAMPLE: begin
        meas_d[idx_q] = y_one;
        xz_d[idx_q]   = y_xz;
        fail_d[idx_q] = row_fail;
        if (idx_q == IDX_W'(3)) begin
          // Pass is graded here so it is already valid during DONE.
          a_d     = 1'b0;
          b_d     = 1'b0;
          done_d  = 1'b1;
          pass_d  = (fail_d == '0);
          state_d = DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          cnt_d   = '0;
          a_d     = idx_d[1];
          b_d     = idx_d[0];
          state_d = SETTLE;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset discards any partial sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      idx_q           <= '0;
      cnt_q           <= '0;
      exp_q           <= '0;
      bus.a           <= 1'b0;
      bus.b           <= 1'b0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.pass        <= 1'b0;
      bus.measured_tt <= '0;
      bus.fail_mask   <= '0;
      bus.xz_mask     <= '0;
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      cnt_q           <= cnt_d;
      exp_q           <= exp_d;
      bus.a           <= a_d;
      bus.b           <= b_d;
      bus.busy        <= busy_d;
      bus.done        <= done_d;
      bus.pass        <= pass_d;
      bus.measured_tt <= meas_d;
      bus.fail_mask   <= fail_d;
      bus.xz_mask     <= xz_d;
    end
  end

endmodule

// File: tb/tb_gate_truth_checker.sv
// Bench for gate_truth_checker: two instances (settle 2 and settle 1) driven
// by behavioural gate models and graded against a table-level reference.
module tb_gate_truth_checker;

  localparam int M_OR   = 0;
  localparam int M_AND  = 1;
  localparam int M_NOR  = 2;
  localparam int M_NAND = 3;
  localparam int M_XOR  = 4;
  localparam int M_X    = 5;
  localparam int M_LAG  = 6;

  logic clk;
  logic rst;
  logic xval;
  logic lag;
  int   mode;
  int   n_tests;
  int   n_fail;

  gate_truth_checker_if i2 ();
  gate_truth_checker_if i1 ();

  gate_truth_checker #(.SETTLE_CYCLES(2)) dut2 (.clk(clk), .rst(rst), .bus(i2));
  gate_truth_checker #(.SETTLE_CYCLES(1)) dut1 (.clk(clk), .rst(rst), .bus(i1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Gate-under-test behaviour for each mode.
  function automatic logic gate_y(input int md, input logic ga, input logic gb);
    case (md)
      M_OR:    return ga | gb;
      M_AND:   return ga & gb;
      M_NOR:   return ~(ga | gb);
      M_NAND:  return ~(ga & gb);
      M_XOR:   return ga ^ gb;
      M_X:     return xval;
      default: return ga | gb;
    endcase
  endfunction

  // OR gate whose output lags its inputs by one clock.
  always_ff @(posedge clk) lag <= i1.a | i1.b;

  assign i2.y = gate_y(mode, i2.a, i2.b);
  assign i1.y = (mode == M_LAG) ? lag : gate_y(mode, i1.a, i1.b);

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: {pass, measured, fail, xz} from the gate's ideal truth table.
  task automatic model(input int md, input logic [3:0] e, output logic [12:0] r);
    logic [3:0] m, f, z;
    logic [1:0] ii;
    logic       v;
    for (int i = 0; i < 4; i++) begin
      ii = 2'(i);
      v = (md == M_LAG) ? gate_y(M_OR, ii[1], ii[0]) : gate_y(md, ii[1], ii[0]);
      m[i] = (v === 1'b1);
      z[i] = !((v === 1'b1) || (v === 1'b0));
      f[i] = z[i] | (m[i] != e[i]);
    end
    r = {(f == 4'd0), m, f, z};
  endtask

  function automatic logic [3:0] ctl(input int sel);
    if (sel == 0) return {i2.a, i2.b, i2.busy, i2.done};
    return {i1.a, i1.b, i1.busy, i1.done};
  endfunction

  function automatic logic [12:0] res(input int sel);
    if (sel == 0) return {i2.pass, i2.measured_tt, i2.fail_mask, i2.xz_mask};
    return {i1.pass, i1.measured_tt, i1.fail_mask, i1.xz_mask};
  endfunction

  task automatic drv(input int sel, input logic st, input logic [3:0] e);
    if (sel == 0) begin
      i2.start = st;
      i2.exp_tt = e;
    end else begin
      i1.start = st;
      i1.exp_tt = e;
    end
  endtask

  // One sweep with per-cycle a/b/busy/done checks and final result checks.
  task automatic sweep(input int sel, input int md, input logic [3:0] e,
                       input bit inject, input bit rst_mid);
    int          s;
    int          t;
    int          r;
    logic [1:0]  rr;
    logic [3:0]  ec;
    logic [12:0] er;
    s = (sel == 0) ? 2 : 1;
    t = 4 * (s + 1) + 1;
    mode = md;
    model(md, e, er);
    @(negedge clk);
    drv(sel, 1'b1, e);
    @(negedge clk);
    drv(sel, 1'b0, inject ? ~e : e);
    for (int n = 1; n <= t; n++) begin
      if (n > 1) @(negedge clk);
      r = (n - 1) / (s + 1);
      rr = 2'(r);
      ec = (n == t) ? 4'b0011 : {rr[1], rr[0], 2'b10};
      check($sformatf("s%0d_m%0d_cyc%0d_ctl", s, md, n), 16'(ctl(sel)), 16'(ec));
      if (rst_mid && n == 2 * (s + 1) + 1) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_ctl", 16'(ctl(sel)), 16'd0);
        check("midrst_res", 16'(res(sel)), 16'd0);
        return;
      end
      if (inject) drv(sel, (n == 3 || n == 7 || n == t), ~e);
    end
    check($sformatf("s%0d_m%0d_done_res", s, md), 16'(res(sel)), 16'(er));
    @(negedge clk);
    drv(sel, 1'b0, e);
    check($sformatf("s%0d_m%0d_idle_ctl", s, md), 16'(ctl(sel)), 16'd0);
    check($sformatf("s%0d_m%0d_hold_res", s, md), 16'(res(sel)), 16'(er));
    @(negedge clk);
    check($sformatf("s%0d_m%0d_noqueue", s, md), 16'(ctl(sel)), 16'd0);
  endtask

  // Level-held start: done must pulse every 4*(S+1)+2 cycles.
  task automatic held_start();
    int times[$];
    int k;
    mode = M_OR;
    @(negedge clk);
    drv(0, 1'b1, 4'b1110);
    for (int c = 0; c < 100 && times.size() < 3; c++) begin
      @(negedge clk);
      if (i2.done) times.push_back(c);
    end
    check("held_pulses", 16'(times.size()), 16'd3);
    if (times.size() == 3) begin
      check("held_gap1", 16'(times[1] - times[0]), 16'd14);
      check("held_gap2", 16'(times[2] - times[1]), 16'd14);
    end
    drv(0, 1'b0, 4'b1110);
    k = 0;
    while (i2.busy && k < 30) begin
      @(negedge clk);
      k++;
    end
    check("held_drain", 16'(i2.busy), 16'd0);
  endtask

  initial begin
    int          sel;
    int          md;
    logic [3:0]  e;
    n_tests = 0;
    n_fail = 0;
    xval = 1'bx;
    mode = M_OR;
    rst = 1'b1;
    drv(0, 1'b0, 4'd0);
    drv(1, 1'b0, 4'd0);
    repeat (3) @(negedge clk);
    check("rst_ctl2", 16'(ctl(0)), 16'd0);
    check("rst_res2", 16'(res(0)), 16'd0);
    check("rst_ctl1", 16'(ctl(1)), 16'd0);
    check("rst_res1", 16'(res(1)), 16'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ctl", 16'(ctl(0)), 16'd0);

    sweep(0, M_OR,  4'b1110, 1'b0, 1'b0);
    sweep(0, M_AND, 4'b1110, 1'b0, 1'b0);
    sweep(0, M_X,   4'b0001, 1'b0, 1'b0);
    sweep(0, M_NOR, 4'b0001, 1'b0, 1'b1);
    sweep(0, M_NOR, 4'b0001, 1'b0, 1'b0);
    sweep(0, M_OR,  4'b1110, 1'b1, 1'b0);
    held_start();
    sweep(1, M_LAG, 4'b1110, 1'b0, 1'b0);
    sweep(1, M_NAND, 4'b0111, 1'b1, 1'b0);

    for (int k = 0; k < 10; k++) begin
      sel = int'($urandom_range(0, 1));
      if (sel == 1 && $urandom_range(0, 1) == 1) md = M_LAG;
      else md = int'($urandom_range(0, 4));
      e = 4'($urandom);
      sweep(sel, md, e, 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
